// File: rtl/acfir_ntt_loader.sv
// Sample-to-beat loader for the NTT stage: packs four samples per 48-bit word,
// zero-pads short frames to a fixed beat count, then sequences start/run/done.
module acfir_ntt_loader #(
  parameter int N       = 128,
  parameter int SW      = 12,
  parameter int BEATS   = 8 * N / 32,
  parameter int RUN_CYC = 8 * ($clog2(N) + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  input  logic [SW-1:0]   s_data,
  input  logic            s_last,
  output logic            s_ready,
  output logic [4*SW-1:0] din,
  output logic            load,
  output logic            start,
  output logic            busy,
  output logic            frame_done,
  output logic            frame_err
);

  localparam int SCW = $clog2(N + 1);
  localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RCW = (RUN_CYC > 1) ? $clog2(RUN_CYC) : 1;

  localparam logic [SCW-1:0] SAMP_MAX  = SCW'(N);
  localparam logic [SCW-1:0] SAMP_LAST = SCW'(N - 1);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS - 1);
  localparam logic [RCW-1:0] RUN_LAST  = RCW'(RUN_CYC - 1);

  typedef enum logic [1:0] {FILL, PAD, START, RUN} state_t;

  state_t            state_q, state_d;
  logic [SCW-1:0]    samp_cnt_q, samp_cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [3*SW-1:0]   pack_q, pack_d;
  logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
  logic              full_q, full_d;
  logic [4*SW-1:0]   din_q, din_d;
  logic              load_q, load_d;
  logic              err_q, err_d;
  logic [RCW-1:0]    run_cnt_q, run_cnt_d;

  logic              ready_int;
  logic              accept;
  logic              final_samp;
  logic              emit;
  logic [4*SW-1:0]   merged;

  assign ready_int  = (state_q == FILL) && (samp_cnt_q < SAMP_MAX);
  assign accept     = s_valid && ready_int;
  assign final_samp = (samp_cnt_q == SAMP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      samp_cnt_q <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      beat_cnt_q <= '0;
      full_q     <= 1'b0;
      din_q      <= '0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
      run_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      beat_cnt_q <= beat_cnt_d;
      full_q     <= full_d;
      din_q      <= din_d;
      load_q     <= load_d;
      err_q      <= err_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    lane_d     = lane_q;
    pack_d     = pack_q;
    beat_cnt_d = beat_cnt_q;
    full_d     = full_q;
    din_d      = din_q;
    load_d     = 1'b0;
    err_d      = err_q;
    run_cnt_d  = run_cnt_q;
    emit       = 1'b0;

    // Current beat so far plus the incoming sample; lanes above it read as zero.
    merged = '0;
    for (int j = 0; j < 3; j++) begin
      if (j < int'(lane_q)) merged[SW*j +: SW] = pack_q[SW*j +: SW];
    end
    merged[SW*int'(lane_q) +: SW] = s_data;

    case (state_q)
      FILL: begin
        if (accept) begin
          pack_d     = merged[3*SW-1:0];
          lane_d     = lane_q + 2'd1;
          samp_cnt_d = samp_cnt_q + SCW'(1);
          if (s_last != final_samp) err_d = 1'b1;
          if ((lane_q == 2'd3) || s_last || final_samp) begin
            emit  = 1'b1;
            din_d = merged;
          end
          if (s_last || final_samp) begin
            state_d = PAD;
            lane_d  = '0;
          end
        end
      end
      PAD: begin
        // full_q means the final beat is on din this cycle; start follows it.
        if (full_q) begin
          state_d = START;
        end else begin
          emit  = 1'b1;
          din_d = '0;
        end
      end
      START: begin
        state_d    = RUN;
        beat_cnt_d = '0;
        full_d     = 1'b0;
        run_cnt_d  = '0;
      end
      RUN: begin
        if (run_cnt_q == RUN_LAST) begin
          state_d    = FILL;
          err_d      = 1'b0;
          samp_cnt_d = '0;
          lane_d     = '0;
          pack_d     = '0;
          run_cnt_d  = '0;
        end else begin
          run_cnt_d = run_cnt_q + RCW'(1);
        end
      end
      default: state_d = FILL;
    endcase

    if (emit) begin
      load_d = 1'b1;
      if (beat_cnt_q == BEAT_LAST) full_d = 1'b1;
      else beat_cnt_d = beat_cnt_q + BCW'(1);
    end
  end

  // Outputs are forced quiet while reset is held, not just after the edge.
  assign s_ready    = !rst && ready_int;
  assign load       = !rst && load_q;
  assign din        = rst ? '0 : din_q;
  assign start      = !rst && (state_q == START);
  assign busy       = !rst && (state_q != FILL);
  assign frame_done = !rst && (state_q == RUN) && (run_cnt_q == RUN_LAST);
  assign frame_err  = frame_done && err_q;

endmodule
